// File: rtl/frame_buf_pingpong.sv
// -----------------------------------------------------------------------------
// frame_buf_pingpong
//
// Double-buffered (ping-pong) pixel frame buffer. The writer fills the back
// bank while the display reader scans the front bank. The banks exchange roles
// only on a reader frame boundary, and only once the back bank holds a complete
// frame. The display therefore never shows a partially written frame.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   we         in   write request to the back bank
//   waddr      in   write pixel address
//   wdata      in   write data, pixel in wdata[3*CH_W-1:0]
//   re         in   read request from the front bank
//   raddr      in   read pixel address
//   frame_end  in   one-cycle pulse at end of a displayed frame
//   r, g, b    out  colour channels of the last accepted read
//   rvalid     out  r/g/b were updated this cycle
//   rd_bank    out  index of the current front bank (back bank is ~rd_bank)
//   back_full  out  back bank holds a complete frame awaiting swap
//   swap       out  one-cycle pulse, the cycle after the banks exchanged
//   wr_drop    out  one-cycle pulse, the previous-cycle write was discarded
// -----------------------------------------------------------------------------
module frame_buf_pingpong #(
  parameter int DEPTH     = 10000,
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 32,
  parameter int CH_W      = 8,
  parameter int BGR_ORDER = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              frame_end,
  output logic [CH_W-1:0]   r,
  output logic [CH_W-1:0]   g,
  output logic [CH_W-1:0]   b,
  output logic              rvalid,
  output logic              rd_bank,
  output logic              back_full,
  output logic              swap,
  output logic              wr_drop
);

  localparam int PIX_W = 3 * CH_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_FILLING = 1'b0,
    ST_FULL    = 1'b1
  } fill_state_t;

  fill_state_t r_state;
  fill_state_t w_state_nx;

  // Pixel storage; contents are deliberately not reset.
  logic [PIX_W-1:0] r_mem0 [DEPTH];
  logic [PIX_W-1:0] r_mem1 [DEPTH];

  logic             r_rd_bank;
  logic             r_swap;
  logic             r_wr_drop;
  logic             r_rvalid;
  logic [CH_W-1:0]  r_r;
  logic [CH_W-1:0]  r_g;
  logic [CH_W-1:0]  r_b;

  logic             w_back_full;
  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic             w_wr_accept;
  logic             w_wr_last;
  logic             w_swap;
  logic             w_rd_fire;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [PIX_W-1:0] w_wr_pix;
  logic [PIX_W-1:0] w_front_pix;
  logic [CH_W-1:0]  w_ch_lo;
  logic [CH_W-1:0]  w_ch_mid;
  logic [CH_W-1:0]  w_ch_hi;
  logic [CH_W-1:0]  w_red;
  logic [CH_W-1:0]  w_blue;

  // Upper write-data bits carry no pixel information.
  generate
    if (DATA_W > PIX_W) begin : g_wdata_pad
      logic w_unused_wdata;
      assign w_unused_wdata = ^wdata[DATA_W-1:PIX_W];
    end
  endgenerate

  assign w_back_full   = (r_state == ST_FULL);
  assign w_wr_in_range = (waddr <= LAST_ADDR);
  assign w_rd_in_range = (raddr <= LAST_ADDR);
  assign w_wr_last     = (waddr == LAST_ADDR);
  assign w_wr_idx      = waddr[IDX_W-1:0];
  assign w_rd_idx      = raddr[IDX_W-1:0];
  assign w_wr_pix      = wdata[PIX_W-1:0];

  // A full back bank refuses writes, so a write in the swap cycle is dropped.
  assign w_wr_accept = we & ~reset & ~w_back_full & w_wr_in_range;
  assign w_swap      = frame_end & w_back_full;
  assign w_rd_fire   = re & w_rd_in_range;

  // Front bank is read with the pre-swap rd_bank, so a read in the swap
  // cycle still returns the frame that was being displayed.
  assign w_front_pix = r_rd_bank ? r_mem1[w_rd_idx] : r_mem0[w_rd_idx];

  assign w_ch_lo  = w_front_pix[CH_W-1:0];
  assign w_ch_mid = w_front_pix[2*CH_W-1:CH_W];
  assign w_ch_hi  = w_front_pix[3*CH_W-1:2*CH_W];
  assign w_red    = (BGR_ORDER != 0) ? w_ch_hi : w_ch_lo;
  assign w_blue   = (BGR_ORDER != 0) ? w_ch_lo : w_ch_hi;

  // Back-bank fill state: completion is triggered only by the last address.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_FILLING: begin
        if (w_wr_accept && w_wr_last) begin
          w_state_nx = ST_FULL;
        end else begin
          w_state_nx = ST_FILLING;
        end
      end
      ST_FULL: begin
        if (frame_end) begin
          w_state_nx = ST_FILLING;
        end else begin
          w_state_nx = ST_FULL;
        end
      end
      default: begin
        w_state_nx = ST_FILLING;
      end
    endcase
  end

  // Back-bank write port; the back bank is always the one not being read.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      if (r_rd_bank) begin
        r_mem0[w_wr_idx] <= w_wr_pix;
      end else begin
        r_mem1[w_wr_idx] <= w_wr_pix;
      end
    end
  end

  // Control state, status pulses and registered read outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FILLING;
      r_rd_bank <= 1'b0;
      r_swap    <= 1'b0;
      r_wr_drop <= 1'b0;
      r_rvalid  <= 1'b0;
      r_r       <= {CH_W{1'b0}};
      r_g       <= {CH_W{1'b0}};
      r_b       <= {CH_W{1'b0}};
    end else begin
      r_state   <= w_state_nx;
      r_swap    <= w_swap;
      r_wr_drop <= we & ~w_wr_accept;
      r_rvalid  <= w_rd_fire;
      if (w_swap) begin
        r_rd_bank <= ~r_rd_bank;
      end
      // Channels hold their last value when no valid read is made.
      if (w_rd_fire) begin
        r_r <= w_red;
        r_g <= w_ch_mid;
        r_b <= w_blue;
      end
    end
  end

  assign rd_bank   = r_rd_bank;
  assign back_full = w_back_full;
  assign swap      = r_swap;
  assign wr_drop   = r_wr_drop;
  assign rvalid    = r_rvalid;
  assign r         = r_r;
  assign g         = r_g;
  assign b         = r_b;

endmodule

// File: doc/frame_buf_pingpong.md
Name: frame_buf_pingpong

Overview:
- Parametrised double-buffered (ping-pong) successor to the single-bank pixel buffer.
- The writer (decoder/DMA side) fills the back bank while the display reader scans the front bank.
- Banks swap only on a reader frame boundary once the back bank is complete, so the display never shows a partially written frame.
- Sits between the image loader and the display adapter timing/output stage.

Parameters:
- DEPTH, 10000, pixels per bank (frame size).
- ADDR_W, 20, address width; must satisfy 2^ADDR_W >= DEPTH.
- DATA_W, 32, write data width; pixel is taken from wdata[3*CH_W-1:0].
- CH_W, 8, bits per colour channel.
- BGR_ORDER, 0, 0: R=pix[CH_W-1:0], G=next CH_W bits, B=top CH_W bits; 1: R and B fields exchanged.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write request to the back bank.
- waddr  in  ADDR_W  write pixel address.
- wdata  in  DATA_W  write data; upper DATA_W-3*CH_W bits ignored.
- re  in  1  read request from the front bank.
- raddr  in  ADDR_W  read pixel address.
- frame_end  in  1  one-cycle pulse from the reader at end of a displayed frame.
- r  out  CH_W  red channel.
- g  out  CH_W  green channel.
- b  out  CH_W  blue channel.
- rvalid  out  1  r/g/b updated this cycle.
- rd_bank  out  1  index of the current front bank.
- back_full  out  1  back bank holds a complete frame awaiting swap.
- swap  out  1  one-cycle pulse, registered, asserted the cycle after a swap.
- wr_drop  out  1  one-cycle pulse: previous-cycle write was discarded.

Behaviour:
- Storage: two banks of DEPTH x 3*CH_W. Memory contents are not reset. The back bank index is always ~rd_bank.
- Reset values: rd_bank=0, back_full=0, swap=0, wr_drop=0, rvalid=0, r=g=b=0.
- Write acceptance: a write is accepted when we=1, back_full=0 and waddr<DEPTH.
  - Accepted write stores wdata[3*CH_W-1:0] at back[waddr] on that clock edge.
- Write rejection: if we=1 and (back_full=1 or waddr>=DEPTH), nothing is stored and wr_drop=1 on the next cycle.
- Back-bank state machine, per back bank:
  - FILLING (back_full=0) -> FULL when a write to waddr=DEPTH-1 is accepted; back_full=1 on the next cycle.
  - Writes need not be sequential. Completion is triggered solely by the write to DEPTH-1.
  - FULL -> FILLING on a swap.
- Swap rule: frame_end=1 while back_full=1 causes the following on that edge:
  - rd_bank toggles;
  - back_full clears;
  - swap=1 on the next cycle.
- frame_end while back_full=0: no swap; the front frame is redisplayed and the writer continues filling.
- Simultaneous final write (waddr=DEPTH-1) and frame_end: the write is stored, but no swap occurs that cycle because back_full is registered. The swap happens at the next frame_end.
- Write in the same cycle as a swap: it is rejected, since back_full=1, and wr_drop pulses.
- Read latency: 1 cycle. If re=1 and raddr<DEPTH at edge N:
  - at N+1, rvalid=1 and r/g/b hold the channels of front[raddr];
  - the front bank is the value of rd_bank at edge N, i.e. pre-swap if a swap occurs at N.
- Read with re=0, or raddr>=DEPTH: rvalid=0 next cycle; r/g/b hold their last values.
- Bank isolation: the reader never reads the bank currently targeted by writes; there is no read/write collision path.
- Channel split: pix[CH_W-1:0] -> r, pix[2CH_W-1:CH_W] -> g, pix[3CH_W-1:2CH_W] -> b. With BGR_ORDER=1, r and b sources are exchanged.
- Reset mid-operation: control state returns to reset values and any in-progress fill is abandoned.
  - Bank 0 becomes front and shows whatever memory holds.
  - The next write fills bank 1.
- No $display/$writemem in synthesizable body; bench-only dumps live in the testbench.

Test Plan:
- Reset, then write pixels 0..DEPTH-1 of bank 1 with wdata=addr (DEPTH=16 in bench); back_full stays 0 until the cycle after the write to 15, then 1; rd_bank=0.
- With back_full=1, pulse frame_end -> next cycle swap=1, rd_bank=1, back_full=0; a read at raddr=5 returns r=8'h05, g=0, b=0, rvalid=1 one cycle later.
- frame_end with back_full=0 -> no swap pulse, rd_bank unchanged; a write of 32'h00AABBCC to waddr 3 while full -> wr_drop=1 next cycle, memory unchanged on readback after swap.
- Final write (waddr=15) in the same cycle as frame_end -> no swap that cycle; the next frame_end swaps. Also, a read issued in the swap cycle returns old-bank data.
- Out-of-range access: re with raddr=16 -> rvalid=0 and r/g/b held; we with waddr=20 -> wr_drop=1. BGR_ORDER=1 instance: wdata 24'h112233 -> r=8'h11, g=8'h22, b=8'h33.
- Assert reset mid-fill (after 7 writes) -> rd_bank=0, back_full=0, outputs 0; refill of 16 pixels completes normally and swap then occurs at frame_end.
